// File: rtl/xrv1_fetch_ctrl_if.sv
// Fetch controller bus bundle: imem request/response channel and IFQ write side.
// master = fetch controller, slave = imem + IFQ environment.
interface xrv1_fetch_ctrl_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ifq_enqueue_o;
  logic [31:0] ifq_data_o;
  logic [31:0] ifq_pc_o;
  logic        ifq_dequeue_i;
  logic        ifq_flush_o;

  modport master (
    output imem_req_o, imem_addr_o, ifq_enqueue_o, ifq_data_o, ifq_pc_o, ifq_flush_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ifq_dequeue_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, ifq_enqueue_o, ifq_data_o, ifq_pc_o, ifq_flush_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ifq_dequeue_i
  );
endinterface

// File: rtl/xrv1_fetch_ctrl.sv
// Instruction fetch sequencer: credit-limited word requests, in-order enqueue, redirect, halt.
// Response enqueues combinationally with rvalid; requests stall on credit exhaustion or gnt=0.
module xrv1_fetch_ctrl #(
  parameter int unsigned ifq_size_p        = 3,
  parameter int unsigned max_outstanding_p = 2,
  parameter logic [31:0] reset_pc_p        = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  input  logic                halt_req_i,
  output logic                halted_o,
  xrv1_fetch_ctrl_if.master   bus
);

  localparam int unsigned cnt_width_lp = $clog2(ifq_size_p + max_outstanding_p + 1);
  localparam int unsigned sum_w_lp     = cnt_width_lp + 1;
  localparam int unsigned ptr_w_lp     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] ifq_size_lp = cnt_width_lp'(ifq_size_p);
  localparam logic [cnt_width_lp-1:0] max_out_lp  = cnt_width_lp'(max_outstanding_p);
  localparam logic [ptr_w_lp-1:0]     last_ptr_lp = ptr_w_lp'(max_outstanding_p - 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    halted_q;
  logic [31:0]             fetch_pc_q;
  logic [cnt_width_lp-1:0] outstanding_q;
  logic [cnt_width_lp-1:0] occupancy_q;
  logic [cnt_width_lp-1:0] discard_q;
  logic [31:0]             pc_fifo_q [max_outstanding_p];
  logic [ptr_w_lp-1:0]     wr_ptr_q;
  logic [ptr_w_lp-1:0]     rd_ptr_q;

  logic                    redirect_act;
  logic [sum_w_lp-1:0]     credit_sum;
  logic                    credit_ok;
  logic                    out_ok;
  logic                    req;
  logic                    grant;
  logic                    rvalid;
  logic                    enq;
  logic                    deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  // BOOT ignores redirect so the very first cycle after reset is never disturbed.
  assign redirect_act = redirect_i & (state_q != BOOT);
  assign credit_sum   = sum_w_lp'(occupancy_q) + sum_w_lp'(outstanding_q);
  assign credit_ok    = credit_sum < sum_w_lp'(ifq_size_p);
  assign out_ok       = outstanding_q < max_out_lp;
  assign req          = (state_q == RUN) & ~redirect_i & ~halt_req_i & credit_ok & out_ok;
  assign grant        = req & bus.imem_gnt_i;
  assign rvalid       = bus.imem_rvalid_i;
  assign deq          = bus.ifq_dequeue_i;
  assign enq          = rvalid & ~redirect_act & (discard_q == '0);

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = {fetch_pc_q[31:2], 2'b00};
  assign bus.ifq_enqueue_o = enq;
  assign bus.ifq_data_o    = enq ? bus.imem_rdata_i : 32'h0;
  assign bus.ifq_pc_o      = enq ? pc_fifo_q[rd_ptr_q] : 32'h0;
  assign bus.ifq_flush_o   = redirect_act;
  assign halted_o          = halted_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT:   state_q <= RUN;
        RUN:    if (halt_req_i) state_q <= DRAIN;
        DRAIN: begin
          if (!halt_req_i) begin
            state_q <= RUN;
          end else if ((outstanding_q == '0) && !rvalid) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Bit1 of a redirect target survives into the first enqueued PC for the aligner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= reset_pc_p;
    end else if (redirect_act) begin
      fetch_pc_q <= redirect_pc_i & ~32'h1;
    end else if (grant) begin
      fetch_pc_q <= {fetch_pc_q[31:2] + 30'd1, 2'b00};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({grant, rvalid})
        2'b10:   outstanding_q <= outstanding_q + cnt_one_lp;
        2'b01:   outstanding_q <= outstanding_q - cnt_one_lp;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Every response still in flight at a redirect belongs to the dead stream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_q <= '0;
    end else if (redirect_act) begin
      discard_q <= outstanding_q - (rvalid ? cnt_one_lp : '0);
    end else if (rvalid && (discard_q != '0)) begin
      discard_q <= discard_q - cnt_one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_q <= '0;
    end else if (redirect_act) begin
      occupancy_q <= '0;
    end else if (enq && !deq) begin
      if (occupancy_q < ifq_size_lp) occupancy_q <= occupancy_q + cnt_one_lp;
    end else if (deq && !enq) begin
      if (occupancy_q != '0) occupancy_q <= occupancy_q - cnt_one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(max_outstanding_p); i++) pc_fifo_q[i] <= 32'h0;
    end else begin
      if (grant) begin
        pc_fifo_q[wr_ptr_q] <= fetch_pc_q;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (rvalid) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  a_no_enq_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    enq |-> (occupancy_q < ifq_size_lp));
  a_rvalid_owed: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_xrv1_fetch_ctrl.sv
// Scoreboard bench for xrv1_fetch_ctrl: directed phases push expected grants/enqueues,
// a monitor process models imem and pops/compares on every grant and enqueue.
module tb_xrv1_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        halted;

  logic        gnt_en = 1'b0;
  logic        resp_en = 1'b0;
  logic        deq = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rd = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cnt = 0;
  int gnt_hist[$];
  int out_m = 0;
  int occ_m = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_enq_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  xrv1_fetch_ctrl_if bus();

  assign bus.imem_gnt_i    = gnt_en;
  assign bus.imem_rvalid_i = rv;
  assign bus.imem_rdata_i  = rd;
  assign bus.ifq_dequeue_i = deq;

  xrv1_fetch_ctrl #(
    .ifq_size_p       (3),
    .max_outstanding_p(2),
    .reset_pc_p       (32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .halt_req_i   (halt_req),
    .halted_o     (halted),
    .bus          (bus)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_enq(input logic [31:0] pc);
    exp_enq_q.push_back({pc, mem_word({pc[31:2], 2'b00})});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int target;
    int k;
    target = gnt_cnt + n;
    k = 0;
    while (gnt_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (gnt_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", gnt_cnt, target);
    end
  endtask

  // imem responder plus scoreboard monitor; inputs settle at +1, sampling at +3.
  initial begin
    logic       g;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if (resp_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        rv = 1'b1;
        rd = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        rv = 1'b0;
        rd = 32'h0;
      end
      #2;
      if (rst_n) begin
        g = bus.imem_req_o & gnt_en;
        if (bus.imem_req_o) chk("credit", 32'((occ_m + out_m < 3) && (out_m < 2)), 32'd1);
        if (g) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got addr %h expected none", bus.imem_addr_o);
          end else begin
            chk("grant_addr", bus.imem_addr_o, exp_addr_q.pop_front());
          end
          pend_addr.push_back(bus.imem_addr_o);
          pend_due.push_back(cyc + 1);
          gnt_cnt++;
          gnt_hist.push_back(cyc);
        end
        if (bus.ifq_enqueue_o) begin
          chk("enq_not_full", 32'(occ_m < 3), 32'd1);
          if (exp_enq_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_enqueue: got pc %h expected none", bus.ifq_pc_o);
          end else begin
            e = exp_enq_q.pop_front();
            chk("enq_pc", bus.ifq_pc_o, e[63:32]);
            chk("enq_data", bus.ifq_data_o, e[31:0]);
          end
        end
        out_m = out_m + int'(g) - int'(rv);
        if (bus.ifq_flush_o) occ_m = 0;
        else if (bus.ifq_enqueue_o && !deq && occ_m < 3) occ_m++;
        else if (deq && !bus.ifq_enqueue_o && occ_m > 0) occ_m--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int h;
    #25;
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst_enq", 32'(bus.ifq_enqueue_o), 32'd0);
    chk("rst_flush", 32'(bus.ifq_flush_o), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // 1: credit limit of three with no consumer
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_enq(32'h0); exp_enq(32'h4); exp_enq(32'h8);
    gnt_en = 1'b1; resp_en = 1'b1; deq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #4 chk("boot_no_req", 32'(bus.imem_req_o), 32'd0);
    step(10);
    #4 chk("t1_credit_stall", 32'(bus.imem_req_o), 32'd0);
    chk("t1_addr_left", 32'(exp_addr_q.size()), 32'd0);
    chk("t1_enq_left", 32'(exp_enq_q.size()), 32'd0);

    // 2: sustained one fetch per cycle with a dequeue every cycle
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(32'h0C + 32'(4 * i));
      exp_enq(32'h0C + 32'(4 * i));
    end
    @(negedge clk);
    deq = 1'b1;
    wait_grants(8, 40);
    gnt_en = 1'b0;
    chk("t2_back_to_back", 32'(gnt_hist[gnt_hist.size()-1] - gnt_hist[gnt_hist.size()-8]), 32'd7);
    step(6);
    chk("t2_enq_left", 32'(exp_enq_q.size()), 32'd0);

    // 3: request held stable while gnt is low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      chk("t3_req_held", 32'(bus.imem_req_o), 32'd1);
      chk("t3_addr_held", bus.imem_addr_o, 32'h2C);
    end
    exp_addr_q.push_back(32'h2C);
    exp_enq(32'h2C);
    @(negedge clk);
    gnt_en = 1'b1;
    wait_grants(1, 5);
    gnt_en = 1'b0;
    #4 chk("t3_addr_next", bus.imem_addr_o, 32'h30);
    step(4);

    // 4: redirect with two responses in flight, compressed target
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h10;
    #4 chk("t4a_flush", 32'(bus.ifq_flush_o), 32'd1);
    chk("t4a_req_off", 32'(bus.imem_req_o), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    exp_addr_q.push_back(32'h10); exp_addr_q.push_back(32'h14);
    resp_en = 1'b0; gnt_en = 1'b1;
    wait_grants(2, 10);
    redirect = 1'b1; redirect_pc = 32'h102;
    #4 chk("t4b_flush", 32'(bus.ifq_flush_o), 32'd1);
    chk("t4b_req_off", 32'(bus.imem_req_o), 32'd0);
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104);
    exp_enq(32'h102); exp_enq(32'h104);
    @(negedge clk);
    redirect = 1'b0; resp_en = 1'b1;
    wait_grants(2, 20);
    gnt_en = 1'b0;
    step(6);
    chk("t4_enq_left", 32'(exp_enq_q.size()), 32'd0);

    // 5: redirect coinciding with rvalid, two outstanding
    exp_addr_q.push_back(32'h108); exp_addr_q.push_back(32'h10C);
    resp_en = 1'b0; gnt_en = 1'b1;
    wait_grants(2, 10);
    gnt_en = 1'b0;
    resp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    #4 chk("t5_flush", 32'(bus.ifq_flush_o), 32'd1);
    chk("t5_drop_same_cycle", 32'(bus.ifq_enqueue_o), 32'd0);
    exp_addr_q.push_back(32'h200); exp_addr_q.push_back(32'h204);
    exp_enq(32'h200); exp_enq(32'h204);
    @(negedge clk);
    redirect = 1'b0; gnt_en = 1'b1;
    wait_grants(2, 20);
    gnt_en = 1'b0;
    step(6);
    chk("t5_enq_left", 32'(exp_enq_q.size()), 32'd0);

    // 6: halt with two outstanding, drain, resume sequentially
    exp_addr_q.push_back(32'h208); exp_addr_q.push_back(32'h20C);
    exp_enq(32'h208); exp_enq(32'h20C);
    resp_en = 1'b0; gnt_en = 1'b1;
    wait_grants(2, 10);
    halt_req = 1'b1;
    k = -1; h = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) resp_en = 1'b1;
      #4;
      chk("t6_no_req", 32'(bus.imem_req_o), 32'd0);
      if (bus.ifq_enqueue_o && bus.ifq_pc_o == 32'h20C) k = cyc;
      if (halted && h < 0) h = cyc;
    end
    chk("t6_last_word_enq", 32'(k >= 0), 32'd1);
    chk("t6_halted_seen", 32'(h >= 0), 32'd1);
    chk("t6_halt_after_drain", 32'((h - k >= 1) && (h - k <= 2)), 32'd1);
    exp_addr_q.push_back(32'h210);
    exp_enq(32'h210);
    @(negedge clk);
    halt_req = 1'b0;
    wait_grants(1, 10);
    gnt_en = 1'b0;
    #4 chk("t6_unhalted", 32'(halted), 32'd0);
    step(4);
    chk("t6_enq_left", 32'(exp_enq_q.size()), 32'd0);

    // 7: asynchronous reset mid-stream with one outstanding
    exp_addr_q.push_back(32'h214);
    resp_en = 1'b0; gnt_en = 1'b1;
    wait_grants(1, 10);
    gnt_en = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    chk("t7_req", 32'(bus.imem_req_o), 32'd0);
    chk("t7_addr", bus.imem_addr_o, 32'h0);
    chk("t7_enq", 32'(bus.ifq_enqueue_o), 32'd0);
    chk("t7_flush", 32'(bus.ifq_flush_o), 32'd0);
    chk("t7_halted", 32'(halted), 32'd0);
    pend_addr.delete();
    pend_due.delete();
    out_m = 0;
    occ_m = 0;
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_enq(32'h0); exp_enq(32'h4); exp_enq(32'h8);
    @(negedge clk);
    rst_n = 1'b1; resp_en = 1'b1; gnt_en = 1'b1;
    wait_grants(3, 20);
    gnt_en = 1'b0;
    step(6);
    chk("final_addr_left", 32'(exp_addr_q.size()), 32'd0);
    chk("final_enq_left", 32'(exp_enq_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
